// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the serial ADC capture block
// and the LED display stub.
package adc_pkg;
    localparam int ADC_RES    = 12;  // sample resolution
    localparam int FRAME_BITS = 16;  // SCLK periods per conversion frame
    localparam int LEAD_BITS  = 4;   // leading header bits, expected zero
    localparam int BIT_CNT_W  = 5;   // wide enough to hold FRAME_BITS

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        DONE  = 2'd2,
        QUIET = 2'd3
    } adc_state_e;
endpackage

// File: rtl/adc_serial_capture_if.sv
// Three-wire serial ADC bus: chip select, serial clock, serial data.
interface adc_serial_capture_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_sdata;

    // Capture side drives select and clock, reads data.
    modport master (output adc_cs_n, output adc_sclk, input adc_sdata);
    // ADC side.
    modport slave  (input adc_cs_n, input adc_sclk, output adc_sdata);
endinterface

// File: rtl/adc_led_stub.sv
// LED display stub: shows the low byte of the sample; when the sample is in
// the top eighth of the range (clipping warning) every LED lights.
module adc_led_stub
    import adc_pkg::*;
(
    input  logic [ADC_RES-1:0] datain,
    output logic [7:0]         leds
);
    localparam int CLIP_BITS = 3;

    assign leds = (&datain[ADC_RES-1 -: CLIP_BITS]) ? 8'hFF : datain[7:0];
endmodule

// File: rtl/adc_sclk_gen.sv
// SCLK generator: idles high while disabled, otherwise toggles every
// CLK_DIV cycles. rise/fall flag that the sclk flop changes on the next edge,
// so a consumer can act on the very edge where sclk goes 0->1.
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sclk_q, sclk_d;
    logic       tc;

    assign tc   = (div_cnt_q == 8'(CLK_DIV - 1));
    assign sclk = sclk_q;

    // Half-period counter and level toggle; disabling clears the counter
    // so each frame starts with a full high phase.
    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        rise      = 1'b0;
        fall      = 1'b0;
        if (!en) begin
            div_cnt_d = 8'd0;
            sclk_d    = 1'b1;
        end else if (tc) begin
            div_cnt_d = 8'd0;
            sclk_d    = ~sclk_q;
            rise      = ~sclk_q;
            fall      = sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= 8'd0;
            sclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end
endmodule

// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture: 16 SCLK periods per frame (CPOL=1, sample on
// the rising SCLK edge), 12-bit result with a 4-bit zero header check,
// followed by a quiet gap with chip select high.
module adc_serial_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8,
    parameter int FREE_RUN     = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    adc_serial_capture_if.master adc,
    output logic [ADC_RES-1:0]   data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam logic AUTO_START = (FREE_RUN != 0);

    adc_state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]     shift_q, shift_d;
    logic [7:0]                quiet_cnt_q, quiet_cnt_d;
    logic                      cs_n_q, cs_n_d;
    logic [ADC_RES-1:0]        data_q, data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      sclk_en, sclk, sclk_rise, sclk_fall;

    // SCLK runs only while bits remain; after the 16th rise it parks high.
    assign sclk_en = (state_q == CONV) && (bit_cnt_q != BIT_CNT_W'(FRAME_BITS));

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign adc.adc_cs_n = cs_n_q;
    assign adc.adc_sclk = sclk;
    assign data         = data_q;
    assign data_valid   = data_valid_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != IDLE);

    // Next-state, shift register, counters and output register updates.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        quiet_cnt_d  = quiet_cnt_q;
        cs_n_d       = cs_n_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || AUTO_START) begin
                    state_d   = CONV;
                    cs_n_d    = 1'b0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            CONV: begin
                if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], adc.adc_sdata};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Release chip select on the same edge as the last sample.
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        cs_n_d = 1'b1;
                    end
                end
            end
            DONE: begin
                data_d       = shift_q[ADC_RES-1:0];
                data_valid_d = 1'b1;
                frame_err_d  = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
                quiet_cnt_d  = 8'd0;
                state_d      = QUIET;
            end
            QUIET: begin
                if (quiet_cnt_q == 8'(QUIET_CYCLES - 1)) begin
                    quiet_cnt_d = 8'd0;
                    state_d     = IDLE;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            quiet_cnt_q  <= 8'd0;
            cs_n_q       <= 1'b1;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            quiet_cnt_q  <= quiet_cnt_d;
            cs_n_q       <= cs_n_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end
endmodule
